id_exe_reg: RTL and testbench
=============================

ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 Parameter DW_PC, default 32, width of the PC field.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-low reset; one clock domain only.
REQ-004 flush  input  1  branch-taken squash; discards all held and incoming beats.
REQ-005 in_valid  input  1  ID stage presents a decoded instruction.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_Val_Rn, in_Val_Rm  input  32 each  register-file operands.
REQ-008 in_Shift_operand  input  12  operand-2 field, passed unmodified to the Val2 generator.
REQ-009 in_Imm  input  32  sign-extended immediate.
REQ-010 in_Val2_Src  input  1  I-bit: immediate operand 2.
REQ-011 in_EXE_CMD  input  4  ALU command.
REQ-012 in_MEM_R_EN, in_MEM_W_EN, in_WB_EN, in_B, in_S  input  1 each  control bits.
REQ-013 in_Dest  input  4  destination register; in_PC  input  DW_PC  instruction PC; in_C  input  1  status carry.
REQ-014 out_valid  output  1  EXE payload valid; out_ready  input  1  EXE stage consumes.
REQ-015 out_* outputs  one per in_* payload field, same widths, registered.
REQ-016 occupancy  output  2  number of held beats (0..2).

Function
REQ-017 Storage: main register (drives out_*) plus one skid register; no combinational path from in_* to out_*.
REQ-018 Accept = in_valid & in_ready; consume = out_valid & out_ready.
REQ-019 in_ready is registered: in_ready = 1 exactly when the skid register is empty.
REQ-020 Latency: a beat accepted into an empty block appears on out_* with out_valid=1 at the next edge.
REQ-021 Throughput: 1 beat/cycle sustained while out_ready=1.
REQ-022 Main empty, or consumed this cycle: skid beat (if any) moves to main; otherwise the accepted beat loads main.
REQ-023 Main full and not consumed: an accepted beat loads skid; in_ready deasserts next cycle.
REQ-024 Skid full and main consumed: skid moves to main, skid empties, in_ready reasserts next cycle; a new beat is not accepted that cycle.
REQ-025 While out_valid=1 and out_ready=0, all out_* shall remain bit-stable.
REQ-026 Ordering strictly FIFO; no beat duplicated or dropped except by flush.
REQ-027 Flush: at the next edge both registers empty, out_valid=0, occupancy=0, in_ready=1; a beat offered in the flush cycle is dropped.
REQ-028 Flush also forces out_WB_EN, out_MEM_R_EN, out_MEM_W_EN, out_B, out_S to 0 at that edge; other payload is don't-care but shall not be X.
REQ-029 Flush has priority over accept and consume in the same cycle; a consume in the flush cycle still counts as delivered.
REQ-030 occupancy = main_valid + skid_valid, registered, never 3.

Reset
REQ-031 rst low asynchronously sets out_valid=0, occupancy=0, all out_* to 0, skid empty; in_ready=1 from the first edge after rst release.
REQ-032 Reset mid-transfer discards both held beats; no beat reappears after release.

Verification
REQ-033 Single beat: in_valid=1, in_Val_Rn=0x0000_0011, in_EXE_CMD=0x2, out_ready=1 -> next cycle out_valid=1, out_Val_Rn=0x0000_0011, out_EXE_CMD=0x2, occupancy=1.
REQ-034 Backpressure: out_ready=0, beats A=0x1, B=0x2 offered on consecutive cycles -> occupancy=2, in_ready=0, out_Val_Rm holds 0x1; release out_ready -> 0x1 then 0x2 in order.
REQ-035 Streaming: 16 beats with in_valid=out_ready=1 continuously -> 16 outputs on 16 consecutive cycles, values 0..15, in_ready constantly 1.
REQ-036 Flush: occupancy=2 with WB_EN=1 beats, flush=1 with in_valid=1 -> next cycle out_valid=0, out_WB_EN=0, occupancy=0, in_ready=1; the flushed-cycle beat never appears.
REQ-037 Async reset: assert rst=0 between edges with occupancy=2 -> out_valid=0 immediately, no clock needed; after release first accepted beat is delivered normally.
REQ-038 Skid drain: occupancy=2, out_ready=1 for one cycle with in_valid=1 -> occupancy=1, new beat not accepted that cycle, in_ready=1 next cycle.

Source files
------------

// File: rtl/id_exe_reg.sv
`default_nettype none
// ============================================================================
// Module  : id_exe_reg
// Brief   : ID/EXE pipeline register with valid/ready handshake, a one-entry
//           skid buffer and branch-flush squash.
// Rev     : 1.0  initial release
// ============================================================================
module id_exe_reg #(
  parameter int DW_PC = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,

  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_Val_Rn,
  input  logic [31:0]      in_Val_Rm,
  input  logic [11:0]      in_Shift_operand,
  input  logic [31:0]      in_Imm,
  input  logic             in_Val2_Src,
  input  logic [3:0]       in_EXE_CMD,
  input  logic             in_MEM_R_EN,
  input  logic             in_MEM_W_EN,
  input  logic             in_WB_EN,
  input  logic             in_B,
  input  logic             in_S,
  input  logic [3:0]       in_Dest,
  input  logic [DW_PC-1:0] in_PC,
  input  logic             in_C,

  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_Val_Rn,
  output logic [31:0]      out_Val_Rm,
  output logic [11:0]      out_Shift_operand,
  output logic [31:0]      out_Imm,
  output logic             out_Val2_Src,
  output logic [3:0]       out_EXE_CMD,
  output logic             out_MEM_R_EN,
  output logic             out_MEM_W_EN,
  output logic             out_WB_EN,
  output logic             out_B,
  output logic             out_S,
  output logic [3:0]       out_Dest,
  output logic [DW_PC-1:0] out_PC,
  output logic             out_C,

  output logic [1:0]       occupancy
);

  typedef struct packed {
    logic [31:0]      val_rn;
    logic [31:0]      val_rm;
    logic [11:0]      shift_operand;
    logic [31:0]      imm;
    logic             val2_src;
    logic [3:0]       exe_cmd;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             wb_en;
    logic             b;
    logic             s;
    logic [3:0]       dest;
    logic [DW_PC-1:0] pc;
    logic             c;
  } payload_t;

  localparam payload_t c_payload_zero = '0;

  payload_t   w_in_beat;
  payload_t   r_main;
  payload_t   r_skid;
  logic       r_main_valid;
  logic       r_skid_valid;
  logic [1:0] r_occupancy;

  logic       w_accept;
  logic       w_consume;
  logic       w_main_load_skid;
  logic       w_main_load_in;
  logic       w_skid_load;
  logic       w_main_valid_nxt;
  logic       w_skid_valid_nxt;

  assign w_in_beat.val_rn        = in_Val_Rn;
  assign w_in_beat.val_rm        = in_Val_Rm;
  assign w_in_beat.shift_operand = in_Shift_operand;
  assign w_in_beat.imm           = in_Imm;
  assign w_in_beat.val2_src      = in_Val2_Src;
  assign w_in_beat.exe_cmd       = in_EXE_CMD;
  assign w_in_beat.mem_r_en      = in_MEM_R_EN;
  assign w_in_beat.mem_w_en      = in_MEM_W_EN;
  assign w_in_beat.wb_en         = in_WB_EN;
  assign w_in_beat.b             = in_B;
  assign w_in_beat.s             = in_S;
  assign w_in_beat.dest          = in_Dest;
  assign w_in_beat.pc            = in_PC;
  assign w_in_beat.c             = in_C;

  // Ready depends only on stored state, so it never combinationally follows out_ready.
  assign in_ready  = ~r_skid_valid;
  assign w_accept  = in_valid & in_ready;
  assign w_consume = r_main_valid & out_ready;

  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    w_main_load_skid = 1'b0;
    w_main_load_in   = 1'b0;
    w_skid_load      = 1'b0;
    if (flush) begin
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (!r_main_valid || w_consume) begin
      if (r_skid_valid) begin
        w_main_load_skid = 1'b1;
        w_main_valid_nxt = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end else begin
        w_main_load_in   = w_accept;
        w_main_valid_nxt = w_accept;
      end
    end else if (w_accept) begin
      w_skid_load      = 1'b1;
      w_skid_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main       <= c_payload_zero;
      r_skid       <= c_payload_zero;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_occupancy  <= 2'd0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_occupancy  <= {1'b0, w_main_valid_nxt} + {1'b0, w_skid_valid_nxt};
      if (flush) begin
        // Side-effecting controls are cleared so a squashed op cannot commit.
        r_main.mem_r_en <= 1'b0;
        r_main.mem_w_en <= 1'b0;
        r_main.wb_en    <= 1'b0;
        r_main.b        <= 1'b0;
        r_main.s        <= 1'b0;
      end else if (w_main_load_skid) begin
        r_main <= r_skid;
      end else if (w_main_load_in) begin
        r_main <= w_in_beat;
      end
      if (w_skid_load) begin
        r_skid <= w_in_beat;
      end
    end
  end

  assign out_valid         = r_main_valid;
  assign occupancy         = r_occupancy;
  assign out_Val_Rn        = r_main.val_rn;
  assign out_Val_Rm        = r_main.val_rm;
  assign out_Shift_operand = r_main.shift_operand;
  assign out_Imm           = r_main.imm;
  assign out_Val2_Src      = r_main.val2_src;
  assign out_EXE_CMD       = r_main.exe_cmd;
  assign out_MEM_R_EN      = r_main.mem_r_en;
  assign out_MEM_W_EN      = r_main.mem_w_en;
  assign out_WB_EN         = r_main.wb_en;
  assign out_B             = r_main.b;
  assign out_S             = r_main.s;
  assign out_Dest          = r_main.dest;
  assign out_PC            = r_main.pc;
  assign out_C             = r_main.c;

endmodule
`default_nettype wire

// File: tb/tb_id_exe_reg.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_exe_reg
// Brief   : Self-checking bench for id_exe_reg: directed table, corner
//           sequences and randomized traffic against a queue model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_id_exe_reg;

  typedef struct packed {
    logic [31:0] rn;
    logic [31:0] rm;
    logic [11:0] sh;
    logic [31:0] imm;
    logic        v2;
    logic [3:0]  cmd;
    logic        mr;
    logic        mw;
    logic        wb;
    logic        b;
    logic        s;
    logic [3:0]  dest;
    logic [31:0] pc;
    logic        c;
  } beat_t;

  typedef struct {
    bit          fl;
    bit          iv;
    bit          ordy;
    logic [31:0] tag;
    logic [3:0]  cmd;
    bit          e_ov;
    bit          e_rdy;
    logic [1:0]  e_occ;
    bit          chk_d;
    logic [31:0] e_tag;
    logic [3:0]  e_cmd;
    bit          chk_ctl;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  beat_t       in_beat = '0;
  logic        in_ready;
  logic        out_valid;
  logic [1:0]  occupancy;
  logic [31:0] out_Val_Rn, out_Val_Rm, out_Imm, out_PC;
  logic [11:0] out_Shift_operand;
  logic [3:0]  out_EXE_CMD, out_Dest;
  logic        out_Val2_Src, out_MEM_R_EN, out_MEM_W_EN, out_WB_EN, out_B, out_S, out_C;
  beat_t       dut_out;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  beat_t q[$];

  always #5 clk = ~clk;

  id_exe_reg #(.DW_PC(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_Val_Rn        (in_beat.rn),
    .in_Val_Rm        (in_beat.rm),
    .in_Shift_operand (in_beat.sh),
    .in_Imm           (in_beat.imm),
    .in_Val2_Src      (in_beat.v2),
    .in_EXE_CMD       (in_beat.cmd),
    .in_MEM_R_EN      (in_beat.mr),
    .in_MEM_W_EN      (in_beat.mw),
    .in_WB_EN         (in_beat.wb),
    .in_B             (in_beat.b),
    .in_S             (in_beat.s),
    .in_Dest          (in_beat.dest),
    .in_PC            (in_beat.pc),
    .in_C             (in_beat.c),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_Val_Rn       (out_Val_Rn),
    .out_Val_Rm       (out_Val_Rm),
    .out_Shift_operand(out_Shift_operand),
    .out_Imm          (out_Imm),
    .out_Val2_Src     (out_Val2_Src),
    .out_EXE_CMD      (out_EXE_CMD),
    .out_MEM_R_EN     (out_MEM_R_EN),
    .out_MEM_W_EN     (out_MEM_W_EN),
    .out_WB_EN        (out_WB_EN),
    .out_B            (out_B),
    .out_S            (out_S),
    .out_Dest         (out_Dest),
    .out_PC           (out_PC),
    .out_C            (out_C),
    .occupancy        (occupancy)
  );

  assign dut_out = {out_Val_Rn, out_Val_Rm, out_Shift_operand, out_Imm, out_Val2_Src,
                    out_EXE_CMD, out_MEM_R_EN, out_MEM_W_EN, out_WB_EN, out_B, out_S,
                    out_Dest, out_PC, out_C};

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t tag_beat(input logic [31:0] tag, input logic [3:0] cmd);
    beat_t r;
    r = '0;
    r.rn  = tag;
    r.rm  = tag;
    r.cmd = cmd;
    r.mr  = 1'b1;
    r.mw  = 1'b1;
    r.wb  = 1'b1;
    r.b   = 1'b1;
    r.s   = 1'b1;
    return r;
  endfunction

  function automatic beat_t rand_beat();
    beat_t r;
    r.rn   = $urandom;
    r.rm   = $urandom;
    r.sh   = 12'($urandom);
    r.imm  = $urandom;
    r.v2   = 1'($urandom);
    r.cmd  = 4'($urandom);
    r.mr   = 1'($urandom);
    r.mw   = 1'($urandom);
    r.wb   = 1'($urandom);
    r.b    = 1'($urandom);
    r.s    = 1'($urandom);
    r.dest = 4'($urandom);
    r.pc   = $urandom;
    r.c    = 1'($urandom);
    return r;
  endfunction

  function automatic vec_t mk(bit fl, bit iv, bit ordy, logic [31:0] tag, logic [3:0] cmd,
                              bit e_ov, bit e_rdy, logic [1:0] e_occ, bit chk_d,
                              logic [31:0] e_tag, logic [3:0] e_cmd, bit chk_ctl);
    vec_t v;
    v.fl = fl; v.iv = iv; v.ordy = ordy; v.tag = tag; v.cmd = cmd;
    v.e_ov = e_ov; v.e_rdy = e_rdy; v.e_occ = e_occ; v.chk_d = chk_d;
    v.e_tag = e_tag; v.e_cmd = e_cmd; v.chk_ctl = chk_ctl;
    return v;
  endfunction

  // Reference: the block is a FIFO of depth 2 that accepts whenever fewer than two are held.
  task automatic model_cycle();
    bit    acc, con, fl;
    beat_t inb;
    acc = in_valid && (q.size() < 2);
    con = (q.size() > 0) && out_ready;
    fl  = flush;
    inb = in_beat;
    tick();
    if (fl) q.delete();
    else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(inb);
    end
    chk("rnd_valid", out_valid, q.size() > 0);
    chk("rnd_occ", occupancy, q.size());
    chk("rnd_ready", in_ready, q.size() < 2);
    if (q.size() > 0) chk("rnd_payload", dut_out, q[0]);
    if (fl) chk("rnd_flush_ctl", {out_WB_EN, out_MEM_R_EN, out_MEM_W_EN, out_B, out_S}, 0);
  endtask

  vec_t tbl[18];

  initial begin
    tbl[0]  = mk(0,1,1,32'h11,4'h2, 1,1,2'd1, 1,32'h11,4'h2, 0);
    tbl[1]  = mk(0,0,1,32'h0 ,4'h0, 0,1,2'd0, 0,32'h0 ,4'h0, 0);
    tbl[2]  = mk(0,1,0,32'h1 ,4'h1, 1,1,2'd1, 1,32'h1 ,4'h1, 0);
    tbl[3]  = mk(0,1,0,32'h2 ,4'h2, 1,0,2'd2, 1,32'h1 ,4'h1, 0);
    tbl[4]  = mk(0,0,0,32'h0 ,4'h0, 1,0,2'd2, 1,32'h1 ,4'h1, 0);
    tbl[5]  = mk(0,0,1,32'h0 ,4'h0, 1,1,2'd1, 1,32'h2 ,4'h2, 0);
    tbl[6]  = mk(0,0,1,32'h0 ,4'h0, 0,1,2'd0, 0,32'h0 ,4'h0, 0);
    tbl[7]  = mk(0,1,0,32'h3 ,4'h3, 1,1,2'd1, 1,32'h3 ,4'h3, 0);
    tbl[8]  = mk(0,1,0,32'h4 ,4'h4, 1,0,2'd2, 1,32'h3 ,4'h3, 0);
    tbl[9]  = mk(0,1,1,32'h5 ,4'h5, 1,1,2'd1, 1,32'h4 ,4'h4, 0);
    tbl[10] = mk(0,0,1,32'h0 ,4'h0, 0,1,2'd0, 0,32'h0 ,4'h0, 0);
    tbl[11] = mk(0,1,0,32'h6 ,4'h6, 1,1,2'd1, 1,32'h6 ,4'h6, 0);
    tbl[12] = mk(0,1,0,32'h7 ,4'h7, 1,0,2'd2, 1,32'h6 ,4'h6, 0);
    tbl[13] = mk(1,1,0,32'h8 ,4'h8, 0,1,2'd0, 0,32'h0 ,4'h0, 1);
    tbl[14] = mk(0,0,1,32'h0 ,4'h0, 0,1,2'd0, 0,32'h0 ,4'h0, 0);
    tbl[15] = mk(0,1,1,32'h9 ,4'h9, 1,1,2'd1, 1,32'h9 ,4'h9, 0);
    tbl[16] = mk(1,1,0,32'hA ,4'hA, 0,1,2'd0, 0,32'h0 ,4'h0, 1);
    tbl[17] = mk(0,0,1,32'h0 ,4'h0, 0,1,2'd0, 0,32'h0 ,4'h0, 0);

    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_payload", dut_out, 0);
    tick();
    tick();
    @(negedge clk) rst = 1'b1;
    tick();
    chk("rst_ready", in_ready, 1);
    chk("rst_valid_after", out_valid, 0);

    // Directed table: single beat, backpressure, skid drain, flush
    for (int i = 0; i < 18; i++) begin
      flush     = tbl[i].fl;
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      in_beat   = tag_beat(tbl[i].tag, tbl[i].cmd);
      tick();
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_occ", i), occupancy, tbl[i].e_occ);
      if (tbl[i].chk_d) begin
        chk($sformatf("tbl%0d_rm", i), out_Val_Rm, tbl[i].e_tag);
        chk($sformatf("tbl%0d_rn", i), out_Val_Rn, tbl[i].e_tag);
        chk($sformatf("tbl%0d_cmd", i), out_EXE_CMD, tbl[i].e_cmd);
      end
      if (tbl[i].chk_ctl)
        chk($sformatf("tbl%0d_flush_ctl", i),
            {out_WB_EN, out_MEM_R_EN, out_MEM_W_EN, out_B, out_S}, 0);
    end
    flush = 1'b0;

    // Streaming: one beat per cycle
    for (int i = 0; i < 16; i++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_beat   = tag_beat(i, 4'(i));
      tick();
      chk($sformatf("stream%0d_valid", i), out_valid, 1);
      chk($sformatf("stream%0d_data", i), out_Val_Rm, i);
      chk($sformatf("stream%0d_ready", i), in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", out_valid, 0);

    // Asynchronous reset with two beats held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_beat   = tag_beat(32'h21, 4'h1);
    tick();
    in_beat   = tag_beat(32'h22, 4'h2);
    tick();
    chk("arst_pre_occ", occupancy, 2);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_payload", dut_out, 0);
    tick();
    @(negedge clk) rst = 1'b1;
    tick();
    chk("arst_rel_ready", in_ready, 1);
    chk("arst_rel_valid", out_valid, 0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_beat   = tag_beat(32'h33, 4'h3);
    tick();
    chk("arst_beat_valid", out_valid, 1);
    chk("arst_beat_data", out_Val_Rm, 32'h33);
    chk("arst_beat_occ", occupancy, 1);
    in_valid = 1'b0;
    tick();
    chk("arst_beat_drain", out_valid, 0);

    // Randomized traffic against the FIFO model
    q.delete();
    for (int n = 0; n < 3000; n++) begin
      flush     = ($urandom_range(0, 24) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_beat   = rand_beat();
      model_cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
